psram_async_wb: RTL and testbench

//  16-bit Wishbone classic slave bridging the Marin bus (intercon slave 4, 16MB @ 0x30000000)
//  to the Nexys cellular RAM in asynchronous mode. Runs one memory access per bus cycle

---
 rtl/psram_async_wb_pkg.sv | 31 +++
 rtl/psram_async_wb_timer.sv | 29 ++
 rtl/psram_async_wb.sv | 206 ++++++++++++++++++++
 tb/tb_psram_async_wb.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_async_wb_pkg.sv
// Shared types and timing defaults for the asynchronous PSRAM Wishbone bridge.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: FSM state encoding, default cycle counts, BCR word, counter width helper.
package psram_async_wb_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_CFG   = 3'd1,
    ST_IDLE  = 3'd2,
    ST_RD    = 3'd3,
    ST_WR    = 3'd4,
    ST_RECOV = 3'd5
  } state_t;

  localparam int          DEF_POWERUP_CYCLES  = 7500;  // 150us at 50MHz
  localparam int          DEF_READ_CYCLES     = 4;
  localparam int          DEF_WRITE_CYCLES    = 4;
  localparam int          DEF_RECOVERY_CYCLES = 2;
  localparam logic [22:0] DEF_BCR_VALUE       = 23'h08_1D1F;

  // Counter wide enough for the largest cycle count plus one spare bit.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/psram_async_wb_timer.sv
// Loadable saturating down-counter shared by every timed state of the bridge.
// Latency: load visible one clock later; o_zero is combinational from the count.
// Backpressure: none. Ports: i_clk, i_rst_n (sync, active-low), i_load, i_value, o_zero.
module psram_async_wb_timer #(
  parameter int W         = 4,
  parameter int RESET_VAL = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= W'(RESET_VAL);
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;  // saturates at zero, never wraps
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/psram_async_wb.sv
// Wishbone classic 16-bit slave driving cellular RAM in asynchronous mode, one access per bus cycle.
// Latency: ack READ_CYCLES+1 / WRITE_CYCLES+1 clocks after accept (1 for sel=00), then RECOVERY_CYCLES.
// Backpressure: requests wait (no ack) during power-up, access and recovery; dropped stb suppresses ack.
// Ports: clk_i/rst_i (sync active-low), wb_* bus side, mem_* pad side (mem_data_t=1 tristates pad).
// Optional feature: define PSRAM_BCR_INIT_EN to write BCR_VALUE to the bus configuration register after power-up.
module psram_async_wb
  import psram_async_wb_pkg::*;
#(
  parameter int          POWERUP_CYCLES  = DEF_POWERUP_CYCLES,
  parameter int          READ_CYCLES     = DEF_READ_CYCLES,
  parameter int          WRITE_CYCLES    = DEF_WRITE_CYCLES,
  parameter int          RECOVERY_CYCLES = DEF_RECOVERY_CYCLES,
  parameter logic [22:0] BCR_VALUE       = DEF_BCR_VALUE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [22:0] mem_addr,
  output logic        mem_clk,
  output logic        mem_cen,
  output logic        mem_cre,
  output logic        mem_oen,
  output logic        mem_wen,
  output logic        mem_adv,
  output logic        mem_ub_n,
  output logic        mem_lb_n,
  input  logic        mem_wait,
  input  logic [15:0] mem_data_i,
  output logic [15:0] mem_data_o,
  output logic        mem_data_t
);

  localparam int CW = cnt_width(POWERUP_CYCLES, READ_CYCLES, WRITE_CYCLES, RECOVERY_CYCLES);
  // Timer is loaded with N-1 so a state lasts exactly N clocks.
  localparam logic [CW-1:0] LD_RD  = CW'(READ_CYCLES - 1);
  localparam logic [CW-1:0] LD_WR  = CW'(WRITE_CYCLES - 1);
  localparam logic [CW-1:0] LD_REC = CW'(RECOVERY_CYCLES - 1);

  state_t        r_state;
  logic          r_ack, r_abort;
  logic [15:0]   r_dat_o, r_data_o;
  logic [22:0]   r_addr;
  logic          r_cen, r_oen, r_wen, r_adv, r_ub_n, r_lb_n, r_data_t;
  logic          w_req, w_accept, w_tmr_zero, w_tmr_load;
  logic [CW-1:0] w_tmr_val;
  logic          w_unused;

  assign w_unused = ^{BCR_VALUE, mem_wait, wb_adr_i[31:24], wb_adr_i[0]};
  assign w_req    = wb_cyc_i & wb_stb_i;
  // A new request is taken in IDLE or on the final recovery edge.
  assign w_accept = w_req && ((r_state == ST_IDLE) || ((r_state == ST_RECOV) && w_tmr_zero));

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    if (w_accept) begin
      w_tmr_load = 1'b1;
      if (wb_sel_i == 2'b00) w_tmr_val = LD_REC;
      else if (wb_we_i)      w_tmr_val = LD_WR;
      else                   w_tmr_val = LD_RD;
    end else begin
      case (r_state)
`ifdef PSRAM_BCR_INIT_EN
        ST_INIT: if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = LD_WR;
        end
`endif
        ST_CFG, ST_RD, ST_WR: if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = LD_REC;
        end
        default: ;
      endcase
    end
  end

  psram_async_wb_timer #(
    .W         (CW),
    .RESET_VAL (POWERUP_CYCLES)
  ) u_timer (
    .i_clk   (clk_i),
    .i_rst_n (rst_i),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_val),
    .o_zero  (w_tmr_zero)
  );

`ifdef PSRAM_BCR_INIT_EN
  logic r_cre;
  assign mem_cre = r_cre;
`else
  assign mem_cre = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state  <= ST_INIT;
      r_ack    <= 1'b0;
      r_abort  <= 1'b0;
      r_dat_o  <= '0;
      r_data_o <= '0;
      r_addr   <= '0;
      r_cen    <= 1'b1;
      r_oen    <= 1'b1;
      r_wen    <= 1'b1;
      r_adv    <= 1'b1;
      r_ub_n   <= 1'b1;
      r_lb_n   <= 1'b1;
      r_data_t <= 1'b1;
`ifdef PSRAM_BCR_INIT_EN
      r_cre    <= 1'b0;
`endif
    end else begin
      r_adv <= 1'b0;
      r_ack <= 1'b0;
      case (r_state)
        ST_INIT: if (w_tmr_zero) begin
`ifdef PSRAM_BCR_INIT_EN
          r_state <= ST_CFG;
          r_cre   <= 1'b1;
          r_addr  <= BCR_VALUE;
          r_cen   <= 1'b0;
          r_wen   <= 1'b0;
          r_ub_n  <= 1'b0;
          r_lb_n  <= 1'b0;
`else
          r_state <= ST_IDLE;
`endif
        end
        ST_CFG: if (w_tmr_zero) begin
          r_state <= ST_RECOV;
          r_cen   <= 1'b1;
          r_wen   <= 1'b1;
          r_ub_n  <= 1'b1;
          r_lb_n  <= 1'b1;
`ifdef PSRAM_BCR_INIT_EN
          r_cre   <= 1'b0;
`endif
        end
        ST_IDLE, ST_RECOV: begin
          // Releases the write-data hold cycle; overridden below by a new write.
          r_data_t <= 1'b1;
          if (w_accept) begin
            r_addr   <= wb_adr_i[23:1];
            r_data_o <= wb_dat_i;
            r_ub_n   <= ~wb_sel_i[1];
            r_lb_n   <= ~wb_sel_i[0];
            r_abort  <= 1'b0;
            if (wb_sel_i == 2'b00) begin
              r_state <= ST_RECOV;
              r_ack   <= 1'b1;
            end else if (wb_we_i) begin
              r_state  <= ST_WR;
              r_cen    <= 1'b0;
              r_wen    <= 1'b0;
              r_data_t <= 1'b0;
            end else begin
              r_state <= ST_RD;
              r_cen   <= 1'b0;
              r_oen   <= 1'b0;
            end
          end else if ((r_state == ST_RECOV) && w_tmr_zero) begin
            r_state <= ST_IDLE;
          end
        end
        ST_RD, ST_WR: begin
          // Sticky: once the master lets go the access still finishes but is not acked.
          if (!w_req) r_abort <= 1'b1;
          if (w_tmr_zero) begin
            r_state <= ST_RECOV;
            r_ack   <= w_req & ~r_abort;
            r_cen   <= 1'b1;
            r_oen   <= 1'b1;
            r_wen   <= 1'b1;
            r_ub_n  <= 1'b1;
            r_lb_n  <= 1'b1;
            if (r_state == ST_RD) r_dat_o <= mem_data_i;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign wb_ack_o   = r_ack;
  assign wb_dat_o   = r_dat_o;
  assign mem_addr   = r_addr;
  assign mem_clk    = 1'b0;
  assign mem_cen    = r_cen;
  assign mem_oen    = r_oen;
  assign mem_wen    = r_wen;
  assign mem_adv    = r_adv;
  assign mem_ub_n   = r_ub_n;
  assign mem_lb_n   = r_lb_n;
  assign mem_data_o = r_data_o;
  assign mem_data_t = r_data_t;

endmodule

// File: tb/tb_psram_async_wb.sv
// Bench for psram_async_wb: bus-level timeline model checked every cycle plus directed literal checks.
// Latency: n/a. Backpressure: master holds stb until ack, or drops it to exercise abort.
// Contains a small PSRAM device model that stores byte lanes while CE#/WE# are low.
module tb_psram_async_wb;

  localparam int P  = 10;
  localparam int R  = 4;
  localparam int W  = 4;
  localparam int RC = 2;
  localparam logic [22:0] BCR = 23'h08_1D1F;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] wb_adr_i;
  logic [15:0] wb_dat_i, wb_dat_o;
  logic [1:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;
  logic [22:0] mem_addr;
  logic        mem_clk, mem_cen, mem_cre, mem_oen, mem_wen, mem_adv, mem_ub_n, mem_lb_n;
  logic        mem_wait;
  logic [15:0] mem_data_i, mem_data_o;
  logic        mem_data_t;

  always #5 clk = ~clk;

  psram_async_wb #(
    .POWERUP_CYCLES (P), .READ_CYCLES (R), .WRITE_CYCLES (W),
    .RECOVERY_CYCLES (RC), .BCR_VALUE (BCR)
  ) dut (
    .clk_i (clk), .rst_i (rst_i),
    .wb_adr_i (wb_adr_i), .wb_dat_i (wb_dat_i), .wb_dat_o (wb_dat_o), .wb_sel_i (wb_sel_i),
    .wb_we_i (wb_we_i), .wb_cyc_i (wb_cyc_i), .wb_stb_i (wb_stb_i), .wb_ack_o (wb_ack_o),
    .mem_addr (mem_addr), .mem_clk (mem_clk), .mem_cen (mem_cen), .mem_cre (mem_cre),
    .mem_oen (mem_oen), .mem_wen (mem_wen), .mem_adv (mem_adv), .mem_ub_n (mem_ub_n),
    .mem_lb_n (mem_lb_n), .mem_wait (mem_wait), .mem_data_i (mem_data_i),
    .mem_data_o (mem_data_o), .mem_data_t (mem_data_t)
  );

  // ---------------- device model ----------------
  logic [15:0] dev [0:63];
  always @(posedge clk) begin
    if (!mem_cen && !mem_wen && !mem_cre) begin
      if (!mem_ub_n) dev[mem_addr[5:0]][15:8] <= mem_data_o[15:8];
      if (!mem_lb_n) dev[mem_addr[5:0]][7:0]  <= mem_data_o[7:0];
    end
  end
  assign mem_data_i = (!mem_cen && !mem_oen) ? dev[mem_addr[5:0]] : 16'hDEAD;

  // ---------------- checking ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- bus-level timeline model ----------------
  // Edges are numbered; "cycle after edge e" is what is sampled at the following negedge.
  // An access accepted at edge N of length L drives strobes in the cycles after edges N..N+L-1,
  // acks in the cycle after edge N+L, and the next request may be taken at edge N+L+RC.
  int          edge_cnt = 0;
  bit          started = 0, last_rst = 0, have_txn = 0, t_we = 0, t_abort = 0;
  int          free_edge = 0, cfg_edge = -1000, t_n = 0, t_len = 0;
  logic [1:0]  t_sel;
  logic [22:0] t_addr;
  logic [15:0] t_dat, t_rd_exp;
  logic [15:0] sb [0:63];

  always @(posedge clk) begin
    edge_cnt++;
    if (!rst_i) begin
      started   = 1;
      last_rst  = 1;
      have_txn  = 0;
`ifdef PSRAM_BCR_INIT_EN
      cfg_edge  = edge_cnt + P + 1;
      free_edge = edge_cnt + P + 1 + W + RC;
`else
      cfg_edge  = -1000;
      free_edge = edge_cnt + P + 2;
`endif
    end else begin
      last_rst = 0;
      if (have_txn && edge_cnt > t_n && edge_cnt <= t_n + t_len && !(wb_cyc_i && wb_stb_i))
        t_abort = 1;
      if (started && edge_cnt >= free_edge && wb_cyc_i && wb_stb_i) begin
        have_txn  = 1;
        t_n       = edge_cnt;
        t_we      = wb_we_i;
        t_sel     = wb_sel_i;
        t_addr    = wb_adr_i[23:1];
        t_dat     = wb_dat_i;
        t_abort   = 0;
        t_len     = (wb_sel_i == 2'b00) ? 0 : (wb_we_i ? W : R);
        free_edge = edge_cnt + t_len + RC;
        if (wb_we_i) begin
          if (wb_sel_i[1]) sb[wb_adr_i[6:1]][15:8] = wb_dat_i[15:8];
          if (wb_sel_i[0]) sb[wb_adr_i[6:1]][7:0]  = wb_dat_i[7:0];
        end else begin
          t_rd_exp = sb[wb_adr_i[6:1]];
        end
      end
    end
  end

  always @(negedge clk) begin
    int  e;
    bit  win, cfgw, hold, ack_e;
    e = edge_cnt;
    if (started) begin
      chk("mem_clk", {31'b0, mem_clk}, 32'd0);
      if (last_rst) begin
        chk("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        chk("rst_dat", {16'b0, wb_dat_o}, 32'd0);
        chk("rst_strobes", {27'b0, mem_cen, mem_oen, mem_wen, mem_ub_n, mem_lb_n}, 32'h1F);
        chk("rst_adv_cre_t", {29'b0, mem_adv, mem_cre, mem_data_t}, 32'b101);
        chk("rst_addr", {9'b0, mem_addr}, 32'd0);
        chk("rst_data_o", {16'b0, mem_data_o}, 32'd0);
      end else begin
        win   = have_txn && e >= t_n && e < t_n + t_len;
        hold  = have_txn && t_we && t_len > 0 && e >= t_n && e <= t_n + t_len;
        cfgw  = e >= cfg_edge && e < cfg_edge + W;
        ack_e = have_txn && !t_abort && e == t_n + t_len;
        chk("adv", {31'b0, mem_adv}, 32'd0);
        chk("cen", {31'b0, mem_cen}, {31'b0, !(win || cfgw)});
        chk("oen", {31'b0, mem_oen}, {31'b0, !(win && !t_we)});
        chk("wen", {31'b0, mem_wen}, {31'b0, !((win && t_we) || cfgw)});
        chk("ub_n", {31'b0, mem_ub_n}, {31'b0, !((win && t_sel[1]) || cfgw)});
        chk("lb_n", {31'b0, mem_lb_n}, {31'b0, !((win && t_sel[0]) || cfgw)});
        chk("cre", {31'b0, mem_cre}, {31'b0, cfgw});
        chk("data_t", {31'b0, mem_data_t}, {31'b0, !hold});
        chk("ack", {31'b0, wb_ack_o}, {31'b0, ack_e});
        if (win || hold) chk("addr", {9'b0, mem_addr}, {9'b0, t_addr});
        if (cfgw) chk("bcr_addr", {9'b0, mem_addr}, {9'b0, BCR});
        if (hold) chk("wdata", {16'b0, mem_data_o}, {16'b0, t_dat});
        if (ack_e && !t_we && t_len > 0) chk("rdata", {16'b0, wb_dat_o}, {16'b0, t_rd_exp});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wb_txn(input logic [31:0] adr, input logic we, input logic [1:0] sel,
                        input logic [15:0] dat, output int lat, output int acc, output int ack_cyc,
                        output logic [15:0] rdat, output logic [22:0] aaddr,
                        output logic ub, output logic lb);
    wb_adr_i = adr; wb_we_i = we; wb_sel_i = sel; wb_dat_i = dat;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    lat = 0; acc = -1; ack_cyc = -1; rdat = '0; aaddr = '0; ub = 1'b1; lb = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      lat++;
      if (acc < 0 && !mem_cen) begin acc = edge_cnt; ub = mem_ub_n; lb = mem_lb_n; end
      if (wb_ack_o) begin ack_cyc = edge_cnt + 1; rdat = wb_dat_o; aaddr = mem_addr; break; end
    end
    if (ack_cyc < 0) chk("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  // Raise a request and return once `want` strobe-active cycles have been seen.
  task automatic start_and_wait(input logic [31:0] adr, input logic we, input logic [15:0] dat,
                                input int want, output int seen, output int acks);
    wb_adr_i = adr; wb_we_i = we; wb_sel_i = 2'b11; wb_dat_i = dat;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    seen = 0; acks = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!mem_cen) seen++;
      if (wb_ack_o) acks++;
      if (seen == want) break;
    end
  endtask

  int          lat, acc, ackc, acc_a, seen, acks;
  logic [15:0] rd;
  logic [22:0] aa;
  logic        ub, lb;

  initial begin
    for (int i = 0; i < 64; i++) begin dev[i] = 16'h0000; sb[i] = 16'h0000; end
    rst_i = 1'b0; mem_wait = 1'b0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b1;

    // Power-up: request held from release. Counter P runs to zero (P+1 edges), IDLE, accept,
    // R strobe cycles: ack seen on negedge P+2+R+1 = 17 after the last reset edge.
`ifdef PSRAM_BCR_INIT_EN
    wb_txn(32'h3000_0020, 1'b0, 2'b11, 16'h0, lat, acc, ackc, rd, aa, ub, lb);
    chk("powerup_latency", lat, 32'd22);
`else
    wb_txn(32'h3000_0020, 1'b0, 2'b11, 16'h0, lat, acc, ackc, rd, aa, ub, lb);
    chk("powerup_latency", lat, 32'd17);
`endif
    chk("powerup_rdata", {16'b0, rd}, 32'h0);

    // Full write then read back.
    wb_txn(32'h3000_0010, 1'b1, 2'b11, 16'hBEEF, lat, acc, ackc, rd, aa, ub, lb);
    chk("wr_latency", lat, 32'd6);
    chk("wr_addr", {9'b0, aa}, 32'h8);
    wb_txn(32'h3000_0010, 1'b0, 2'b11, 16'h0, lat, acc, ackc, rd, aa, ub, lb);
    chk("rd_beef", {16'b0, rd}, 32'hBEEF);
    chk("rd_addr", {9'b0, aa}, 32'h8);
    chk("rd_ack_at_n5", ackc - acc, 32'd5);
    acc_a = acc;
    // Back-to-back: next accept exactly at N+6.
    wb_txn(32'h3000_0010, 1'b0, 2'b11, 16'h0, lat, acc, ackc, rd, aa, ub, lb);
    chk("next_accept_n6", acc - acc_a, 32'd6);

    // Upper-byte write.
    wb_txn(32'h3000_0010, 1'b1, 2'b10, 16'h12AB, lat, acc, ackc, rd, aa, ub, lb);
    chk("ub_lane_ub_n", {31'b0, ub}, 32'd0);
    chk("ub_lane_lb_n", {31'b0, lb}, 32'd1);
    wb_txn(32'h3000_0010, 1'b0, 2'b11, 16'h0, lat, acc, ackc, rd, aa, ub, lb);
    chk("rd_12ef", {16'b0, rd}, 32'h12EF);

    // Lower-byte write to word 9.
    wb_txn(32'h3000_0012, 1'b1, 2'b01, 16'h3456, lat, acc, ackc, rd, aa, ub, lb);
    chk("lb_lane_ub_n", {31'b0, ub}, 32'd1);
    chk("lb_lane_lb_n", {31'b0, lb}, 32'd0);
    wb_txn(32'h3000_0012, 1'b0, 2'b11, 16'h0, lat, acc, ackc, rd, aa, ub, lb);
    chk("rd_0056", {16'b0, rd}, 32'h0056);

    // No byte lanes: immediate ack, no memory strobe, contents untouched.
    wb_txn(32'h3000_0010, 1'b1, 2'b00, 16'hFFFF, lat, acc, ackc, rd, aa, ub, lb);
    chk("sel00_latency", lat, 32'd2);
    chk("sel00_no_strobe", acc, 32'hFFFF_FFFF);
    wb_txn(32'h3000_0010, 1'b0, 2'b11, 16'h0, lat, acc, ackc, rd, aa, ub, lb);
    chk("sel00_rd_12ef", {16'b0, rd}, 32'h12EF);

    // Master abandons a read after two strobe cycles.
    start_and_wait(32'h3000_0010, 1'b0, 16'h0, 2, seen, acks);
    chk("abort_rd_seen", seen, 32'd2);
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (wb_ack_o) acks++;
    end
    chk("abort_rd_no_ack", acks, 32'd0);

    // Reset pulse in the middle of a write.
    start_and_wait(32'h3000_0030, 1'b1, 16'h5A5A, 2, seen, acks);
    chk("abort_wr_seen", seen, 32'd2);
    @(posedge clk); #1;
    rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_cen", {31'b0, mem_cen}, 32'd1);
    chk("midrst_wen", {31'b0, mem_wen}, 32'd1);
    chk("midrst_ack", {31'b0, wb_ack_o | acks[0]}, 32'd0);

    // Recovers after the power-up wait re-runs.
    wb_txn(32'h3000_0010, 1'b0, 2'b11, 16'h0, lat, acc, ackc, rd, aa, ub, lb);
    chk("post_rst_rd", {16'b0, rd}, 32'h12EF);
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
